// File: rtl/blackjack_game_ctrl_if.sv
// Signal bundle between the BlackJack game sequencer and its surroundings:
// player buttons, the card RNG, and the hex/LED display logic.
interface blackjack_game_ctrl_if #(
  parameter int SCORE_W = 8
);
  logic               deal;
  logic               hit;
  logic               stand;
  logic [4:0]         card_in;
  logic               draw_n;
  logic [4:0]         player_total;
  logic [4:0]         dealer_total;
  logic               dealer_reveal;
  logic [1:0]         result;
  logic               busy;
  logic [SCORE_W-1:0] wins;
  logic [SCORE_W-1:0] losses;

  // Buttons/RNG side drives requests and cards, observes game status.
  modport master (
    output deal, hit, stand, card_in,
    input  draw_n, player_total, dealer_total, dealer_reveal, result, busy, wins, losses
  );

  // The sequencer itself.
  modport slave (
    input  deal, hit, stand, card_in,
    output draw_n, player_total, dealer_total, dealer_reveal, result, busy, wins, losses
  );
endinterface

// File: rtl/blackjack_game_ctrl.sv
// BlackJack game sequencer: draws cards from the RNG, tracks both hands,
// runs deal / player / dealer phases and keeps saturating win/loss scores.
module blackjack_game_ctrl #(
  parameter int DEALER_STAND = 17,
  parameter int SCORE_W      = 8
) (
  input logic                  clock,
  input logic                  reset_n,
  blackjack_game_ctrl_if.slave bus
);

  localparam logic [2:0] IDLE        = 3'd0;
  localparam logic [2:0] DRAW_REQ    = 3'd1;
  localparam logic [2:0] DRAW_CAP    = 3'd2;
  localparam logic [2:0] PLAYER_TURN = 3'd3;
  localparam logic [2:0] DEALER_TURN = 3'd4;
  localparam logic [2:0] COMPARE     = 3'd5;
  localparam logic [2:0] RESULT      = 3'd6;

  // Which phase issued the current draw.
  localparam logic [1:0] CTX_DEAL   = 2'd0;
  localparam logic [1:0] CTX_PLAYER = 2'd1;
  localparam logic [1:0] CTX_DEALER = 2'd2;

  localparam logic [1:0] RES_NONE   = 2'b00;
  localparam logic [1:0] RES_PLAYER = 2'b01;
  localparam logic [1:0] RES_DEALER = 2'b10;
  localparam logic [1:0] RES_PUSH   = 2'b11;

  localparam logic [4:0]         STAND_AT  = 5'(DEALER_STAND);
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  logic [2:0]         state;
  logic [1:0]         ctx;
  logic [1:0]         deal_cnt;
  logic [4:0]         p_hard;
  logic               p_ace;
  logic [4:0]         d_hard;
  logic               d_ace;
  logic               reveal;
  logic [1:0]         result_q;
  logic [SCORE_W-1:0] wins_q;
  logic [SCORE_W-1:0] losses_q;

  logic       card_ok;
  logic       to_dealer;
  logic [4:0] sum_nx;
  logic       ace_nx;
  logic [4:0] eff_nx;
  logic [4:0] p_eff;
  logic [4:0] d_eff;

  // An ace counts 11 whenever that does not bust the hand.
  function automatic logic [4:0] eff_total(input logic [4:0] hard, input logic ace);
    return (ace && hard <= 5'd11) ? hard + 5'd10 : hard;
  endfunction

  assign p_eff = eff_total(p_hard, p_ace);
  assign d_eff = eff_total(d_hard, d_ace);

  // During the deal, even-numbered cards go to the player, odd to the dealer.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    to_dealer = 1'b0;
    sum_nx    = '0;
    ace_nx    = 1'b0;
    eff_nx    = '0;
    card_ok   = (bus.card_in != 5'd0) && (bus.card_in <= 5'd10);
    if (ctx == CTX_DEALER || (ctx == CTX_DEAL && deal_cnt[0])) to_dealer = 1'b1;
    if (to_dealer) begin
      sum_nx = d_hard + bus.card_in;
      ace_nx = d_ace | (bus.card_in == 5'd1);
    end else begin
      sum_nx = p_hard + bus.card_in;
      ace_nx = p_ace | (bus.card_in == 5'd1);
    end
    eff_nx = eff_total(sum_nx, ace_nx);
  end

  // NOTE: asynchronous reset in the sensitivity list; all state uses non-blocking assignment.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      ctx      <= CTX_DEAL;
      deal_cnt <= '0;
      p_hard   <= '0;
      p_ace    <= 1'b0;
      d_hard   <= '0;
      d_ace    <= 1'b0;
      reveal   <= 1'b0;
      result_q <= RES_NONE;
      wins_q   <= '0;
      losses_q <= '0;
    end else begin
      case (state)
        IDLE, RESULT: begin
          if (bus.deal) begin
            p_hard   <= '0;
            p_ace    <= 1'b0;
            d_hard   <= '0;
            d_ace    <= 1'b0;
            reveal   <= 1'b0;
            result_q <= RES_NONE;
            deal_cnt <= '0;
            ctx      <= CTX_DEAL;
            state    <= DRAW_REQ;
          end
        end

        DRAW_REQ: state <= DRAW_CAP;

        DRAW_CAP: begin
          if (!card_ok) begin
            state <= DRAW_REQ;
          end else begin
            if (to_dealer) begin
              d_hard <= sum_nx;
              d_ace  <= ace_nx;
            end else begin
              p_hard <= sum_nx;
              p_ace  <= ace_nx;
            end
            case (ctx)
              CTX_DEAL: begin
                // Fourth card is the dealer's, so the player's hand is already final.
                if (deal_cnt == 2'd3) begin
                  if (p_eff == 5'd21) begin
                    reveal <= 1'b1;
                    state  <= DEALER_TURN;
                  end else begin
                    state  <= PLAYER_TURN;
                  end
                end else begin
                  deal_cnt <= deal_cnt + 2'd1;
                  state    <= DRAW_REQ;
                end
              end
              CTX_PLAYER: begin
                if (sum_nx > 5'd21) begin
                  reveal   <= 1'b1;
                  result_q <= RES_DEALER;
                  if (losses_q != SCORE_MAX) losses_q <= losses_q + 1'b1;
                  state    <= RESULT;
                end else if (eff_nx == 5'd21) begin
                  reveal <= 1'b1;
                  state  <= DEALER_TURN;
                end else begin
                  state <= PLAYER_TURN;
                end
              end
              default: begin
                if (sum_nx > 5'd21) begin
                  result_q <= RES_PLAYER;
                  if (wins_q != SCORE_MAX) wins_q <= wins_q + 1'b1;
                  state    <= RESULT;
                end else begin
                  state <= DEALER_TURN;
                end
              end
            endcase
          end
        end

        PLAYER_TURN: begin
          if (bus.stand) begin
            reveal <= 1'b1;
            state  <= DEALER_TURN;
          end else if (bus.hit) begin
            ctx   <= CTX_PLAYER;
            state <= DRAW_REQ;
          end
        end

        DEALER_TURN: begin
          reveal <= 1'b1;
          if (d_eff < STAND_AT) begin
            ctx   <= CTX_DEALER;
            state <= DRAW_REQ;
          end else begin
            state <= COMPARE;
          end
        end

        COMPARE: begin
          state <= RESULT;
          if (p_eff > d_eff) begin
            result_q <= RES_PLAYER;
            if (wins_q != SCORE_MAX) wins_q <= wins_q + 1'b1;
          end else if (d_eff > p_eff) begin
            result_q <= RES_DEALER;
            if (losses_q != SCORE_MAX) losses_q <= losses_q + 1'b1;
          end else begin
            result_q <= RES_PUSH;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.draw_n        = (state != DRAW_REQ);
  assign bus.player_total  = p_eff;
  assign bus.dealer_total  = d_eff;
  assign bus.dealer_reveal = reveal;
  assign bus.result        = result_q;
  assign bus.busy          = !(state == IDLE || state == PLAYER_TURN || state == RESULT);
  assign bus.wins          = wins_q;
  assign bus.losses        = losses_q;

endmodule

// File: tb/tb_blackjack_game_ctrl.sv
// Directed bench for the BlackJack sequencer: an RNG model feeds a queue of
// scripted cards whenever draw_n is low; each step checks hand-computed values.
module tb_blackjack_game_ctrl;

  logic clock;
  logic reset_n;

  blackjack_game_ctrl_if #(.SCORE_W(8)) bif ();

  blackjack_game_ctrl #(
    .DEALER_STAND(17),
    .SCORE_W     (8)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bif)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int deal_cyc = 0;
  int draw_cnt = 0;
  int base;
  int card_q[$];
  int draw_cyc_q[$];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc++;

  // RNG model: a new card appears while draw_n is low, ahead of the capture cycle.
  always @(negedge clock) begin
    if (bif.draw_n === 1'b0) begin
      draw_cnt++;
      draw_cyc_q.push_back(cyc - deal_cyc);
      if (card_q.size() > 0) bif.card_in = 5'(card_q.pop_front());
      else                   bif.card_in = 5'd10;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_deal();
    @(negedge clock);
    bif.deal = 1'b1;
    deal_cyc = cyc;
    @(negedge clock);
    bif.deal = 1'b0;
  endtask

  task automatic do_buttons(input logic h, input logic s);
    @(negedge clock);
    bif.hit   = h;
    bif.stand = s;
    @(negedge clock);
    bif.hit   = 1'b0;
    bif.stand = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (bif.busy !== 1'b0 && n < 500) begin
      @(negedge clock);
      n++;
    end
    check(tag, 32'(bif.busy), 0);
  endtask

  task automatic win_hand();
    card_q.push_back(10); card_q.push_back(10);
    card_q.push_back(10); card_q.push_back(7);
    do_deal();
    wait_idle("sat_deal_idle");
    do_buttons(1'b0, 1'b1);
    wait_idle("sat_stand_idle");
  endtask

  initial begin
    reset_n     = 1'b0;
    bif.deal    = 1'b0;
    bif.hit     = 1'b0;
    bif.stand   = 1'b0;
    bif.card_in = 5'd0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    // Reset state
    check("rst_draw_n", 32'(bif.draw_n), 1);
    check("rst_player", 32'(bif.player_total), 0);
    check("rst_dealer", 32'(bif.dealer_total), 0);
    check("rst_result", 32'(bif.result), 0);
    check("rst_wins",   32'(bif.wins), 0);
    check("rst_losses", 32'(bif.losses), 0);
    check("rst_busy",   32'(bif.busy), 0);
    check("rst_reveal", 32'(bif.dealer_reveal), 0);

    // Reset mid-deal abandons the hand
    card_q = '{5, 5, 5, 5};
    do_deal();
    repeat (2) @(negedge clock);
    reset_n = 1'b0;
    #1;
    check("midrst_draw_n", 32'(bif.draw_n), 1);
    check("midrst_player", 32'(bif.player_total), 0);
    check("midrst_busy",   32'(bif.busy), 0);
    check("midrst_result", 32'(bif.result), 0);
    @(negedge clock);
    reset_n = 1'b1;
    card_q.delete();
    base = draw_cnt;
    repeat (4) @(negedge clock);
    check("midrst_no_draw", 32'(draw_cnt - base), 0);

    // Deal timing: P10 D7 P8 D9
    card_q = '{10, 7, 8, 9};
    draw_cyc_q.delete();
    do_deal();
    wait_idle("deal_idle");
    check("deal_ndraw", 32'(draw_cyc_q.size()), 4);
    check("deal_cyc0", 32'(draw_cyc_q[0]), 1);
    check("deal_cyc1", 32'(draw_cyc_q[1]), 3);
    check("deal_cyc2", 32'(draw_cyc_q[2]), 5);
    check("deal_cyc3", 32'(draw_cyc_q[3]), 7);
    check("deal_player", 32'(bif.player_total), 18);
    check("deal_dealer", 32'(bif.dealer_total), 16);
    check("deal_reveal", 32'(bif.dealer_reveal), 0);
    check("deal_result", 32'(bif.result), 0);
    // Dealer 16 draws an ace: hard 17, ace cannot count 11 -> 17, stands
    card_q = '{1};
    do_buttons(1'b0, 1'b1);
    wait_idle("deal_stand_idle");
    check("deal_dealer_fin", 32'(bif.dealer_total), 17);
    check("deal_fin_result", 32'(bif.result), 1);
    check("deal_fin_wins",   32'(bif.wins), 1);
    check("deal_fin_reveal", 32'(bif.dealer_reveal), 1);

    // Soft 21 on the deal: P1 D10 P10 D10 -> straight to dealer, 21 vs 20
    card_q = '{1, 10, 10, 10};
    base = draw_cnt;
    do_deal();
    check("bj_reveal_clr", 32'(bif.dealer_reveal), 0);
    check("bj_result_clr", 32'(bif.result), 0);
    wait_idle("bj_idle");
    check("bj_ndraw",  32'(draw_cnt - base), 4);
    check("bj_player", 32'(bif.player_total), 21);
    check("bj_dealer", 32'(bif.dealer_total), 20);
    check("bj_result", 32'(bif.result), 1);
    check("bj_wins",   32'(bif.wins), 2);

    // Player bust: P10 D5 P6 D5, hit 9 -> 25
    card_q = '{10, 5, 6, 5};
    do_deal();
    wait_idle("bust_deal_idle");
    check("bust_player0", 32'(bif.player_total), 16);
    card_q = '{9};
    base = draw_cnt;
    do_buttons(1'b1, 1'b0);
    wait_idle("bust_idle");
    check("bust_ndraw",  32'(draw_cnt - base), 1);
    check("bust_player", 32'(bif.player_total), 25);
    check("bust_dealer", 32'(bif.dealer_total), 10);
    check("bust_result", 32'(bif.result), 2);
    check("bust_losses", 32'(bif.losses), 1);
    check("bust_wins",   32'(bif.wins), 2);
    check("bust_reveal", 32'(bif.dealer_reveal), 1);

    // Dealer soft 17 stands: P10 D1 P9 D6
    card_q = '{10, 1, 9, 6};
    do_deal();
    wait_idle("s17_deal_idle");
    check("s17_dealer0", 32'(bif.dealer_total), 17);
    base = draw_cnt;
    do_buttons(1'b0, 1'b1);
    wait_idle("s17_idle");
    check("s17_ndraw",  32'(draw_cnt - base), 0);
    check("s17_result", 32'(bif.result), 1);
    check("s17_wins",   32'(bif.wins), 3);

    // Dealer hard 16 draws 3 -> 19, push against player 19
    card_q = '{10, 10, 9, 6};
    do_deal();
    wait_idle("push_deal_idle");
    check("push_player", 32'(bif.player_total), 19);
    check("push_dealer0", 32'(bif.dealer_total), 16);
    card_q = '{3};
    base = draw_cnt;
    do_buttons(1'b0, 1'b1);
    wait_idle("push_idle");
    check("push_ndraw",  32'(draw_cnt - base), 1);
    check("push_dealer", 32'(bif.dealer_total), 19);
    check("push_result", 32'(bif.result), 3);
    check("push_wins",   32'(bif.wins), 3);
    check("push_losses", 32'(bif.losses), 1);

    // Invalid cards 0 and 15 are redrawn: P10 D(0)5 P7 D(15)8
    card_q = '{10, 0, 5, 7, 15, 8};
    base = draw_cnt;
    do_deal();
    wait_idle("inv_idle");
    check("inv_ndraw",  32'(draw_cnt - base), 6);
    check("inv_player", 32'(bif.player_total), 17);
    check("inv_dealer", 32'(bif.dealer_total), 13);
    check("inv_result", 32'(bif.result), 0);
    // hit+stand together: stand wins; dealer 13 draws 4 -> 17, push
    card_q = '{4};
    base = draw_cnt;
    do_buttons(1'b1, 1'b1);
    wait_idle("prio_idle");
    check("prio_ndraw",  32'(draw_cnt - base), 1);
    check("prio_player", 32'(bif.player_total), 17);
    check("prio_dealer", 32'(bif.dealer_total), 17);
    check("prio_result", 32'(bif.result), 3);
    // hit in RESULT is ignored
    base = draw_cnt;
    do_buttons(1'b1, 1'b0);
    repeat (3) @(negedge clock);
    check("ign_ndraw",  32'(draw_cnt - base), 0);
    check("ign_busy",   32'(bif.busy), 0);
    check("ign_result", 32'(bif.result), 3);

    // Win counter saturation: 3 wins so far, 252 more reach 255
    for (int i = 0; i < 252; i++) win_hand();
    check("sat_wins_255", 32'(bif.wins), 255);
    win_hand();
    check("sat_result", 32'(bif.result), 1);
    check("sat_wins_hold", 32'(bif.wins), 255);
    check("sat_losses", 32'(bif.losses), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
